// File: rtl/n1_ips_ctrl.sv
// n1_ips_ctrl: intermediate parameter stack controller; spills/fills cells over a Wishbone-style bus.
// Optional macro IPS_SAFE_EN: blocks overflow/underflow and reports them on ips2excpt_of_o/uf_o.

module n1_ips_ctrl #(
    parameter int SP_WIDTH   = 12,
    parameter int CELL_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  sync_rst_i,
    input  logic                  us2ips_psh_i,
    input  logic                  us2ips_pul_i,
    input  logic                  us2ips_rst_i,
    input  logic [CELL_WIDTH-1:0] us2ips_psh_data_i,
    output logic                  ips2us_ack_o,
    output logic [CELL_WIDTH-1:0] ips2us_pul_data_o,
    output logic                  ips2us_empty_o,
    output logic                  ips2us_full_o,
    output logic                  ips2dsp_psh_o,
    output logic                  ips2dsp_pul_o,
    output logic                  ips2dsp_rst_o,
    input  logic [SP_WIDTH-1:0]   dsp2ips_lsp_i,
    output logic                  ips2ram_cyc_o,
    output logic                  ips2ram_stb_o,
    output logic                  ips2ram_we_o,
    output logic [SP_WIDTH-1:0]   ips2ram_adr_o,
    output logic [CELL_WIDTH-1:0] ips2ram_dat_o,
    input  logic                  ram2ips_ack_i,
    input  logic [CELL_WIDTH-1:0] ram2ips_dat_i,
    output logic                  ips2excpt_of_o,
    output logic                  ips2excpt_uf_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PSH  = 3'd1,
        ST_PUL  = 3'd2,
        ST_CLR  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [SP_WIDTH:0]     DEPTH_ZERO = {(SP_WIDTH+1){1'b0}};
    localparam logic [SP_WIDTH:0]     DEPTH_ONE  = {{SP_WIDTH{1'b0}}, 1'b1};
    localparam logic [SP_WIDTH:0]     DEPTH_MAX  = {1'b1, {SP_WIDTH{1'b0}}};
    localparam logic [SP_WIDTH-1:0]   ADR_ZERO   = {SP_WIDTH{1'b0}};
    localparam logic [SP_WIDTH-1:0]   ADR_ONE    = SP_WIDTH'(1'b1);
    localparam logic [CELL_WIDTH-1:0] CELL_ZERO  = {CELL_WIDTH{1'b0}};

    state_t                  state_r;
    state_t                  state_s;
    logic [SP_WIDTH:0]       depth_r;
    logic [SP_WIDTH:0]       depth_s;
    logic                    empty_r;
    logic                    full_r;
    logic                    ack_r;
    logic [CELL_WIDTH-1:0]   pul_data_r;
    logic                    dsp_psh_r;
    logic                    dsp_pul_r;
    logic                    dsp_rst_r;
    logic                    cyc_r;
    logic                    we_r;
    logic [SP_WIDTH-1:0]     adr_r;
    logic [SP_WIDTH-1:0]     adr_s;
    logic [CELL_WIDTH-1:0]   dat_r;
    logic [CELL_WIDTH-1:0]   dat_s;
    logic                    cyc_s;
    logic                    psh_done_s;
    logic                    pul_done_s;
`ifdef IPS_SAFE_EN
    logic                    of_r;
    logic                    uf_r;
    logic                    of_s;
    logic                    uf_s;
`endif

    // Next-state, depth and bus-address decode; rst in PSH/PUL aborts and masks a same-cycle ack_i.
    always_comb begin
        state_s    = state_r;
        depth_s    = depth_r;
        adr_s      = adr_r;
        dat_s      = dat_r;
        psh_done_s = 1'b0;
        pul_done_s = 1'b0;
`ifdef IPS_SAFE_EN
        of_s       = 1'b0;
        uf_s       = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                adr_s = ADR_ZERO;
                dat_s = CELL_ZERO;
                if (us2ips_rst_i) begin
                    state_s = ST_CLR;
                end else if (us2ips_psh_i) begin
`ifdef IPS_SAFE_EN
                    if (full_r) begin
                        state_s = ST_DONE;
                        of_s    = 1'b1;
                    end else begin
                        state_s = ST_PSH;
                        adr_s   = dsp2ips_lsp_i;
                        dat_s   = us2ips_psh_data_i;
                    end
`else
                    state_s = ST_PSH;
                    adr_s   = dsp2ips_lsp_i;
                    dat_s   = us2ips_psh_data_i;
`endif
                end else if (us2ips_pul_i) begin
`ifdef IPS_SAFE_EN
                    if (empty_r) begin
                        state_s = ST_DONE;
                        uf_s    = 1'b1;
                    end else begin
                        state_s = ST_PUL;
                        adr_s   = dsp2ips_lsp_i + ADR_ONE;
                    end
`else
                    state_s = ST_PUL;
                    adr_s   = dsp2ips_lsp_i + ADR_ONE;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PSH: begin
                if (us2ips_rst_i) begin
                    state_s = ST_CLR;
                end else if (ram2ips_ack_i) begin
                    state_s    = ST_DONE;
                    psh_done_s = 1'b1;
                    depth_s    = depth_r + DEPTH_ONE;
                end else begin
                    state_s = ST_PSH;
                end
            end
            ST_PUL: begin
                if (us2ips_rst_i) begin
                    state_s = ST_CLR;
                end else if (ram2ips_ack_i) begin
                    state_s    = ST_DONE;
                    pul_done_s = 1'b1;
                    depth_s    = depth_r - DEPTH_ONE;
                end else begin
                    state_s = ST_PUL;
                end
            end
            ST_CLR: begin
                state_s = ST_DONE;
                depth_s = DEPTH_ZERO;
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        cyc_s = (state_s == ST_PSH) || (state_s == ST_PUL);
    end

    // State and all outputs registered from the next-state decode, so every output is glitch-free.
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            state_r    <= ST_IDLE;
            depth_r    <= DEPTH_ZERO;
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            ack_r      <= 1'b0;
            pul_data_r <= CELL_ZERO;
            dsp_psh_r  <= 1'b0;
            dsp_pul_r  <= 1'b0;
            dsp_rst_r  <= 1'b0;
            cyc_r      <= 1'b0;
            we_r       <= 1'b0;
            adr_r      <= ADR_ZERO;
            dat_r      <= CELL_ZERO;
`ifdef IPS_SAFE_EN
            of_r       <= 1'b0;
            uf_r       <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            depth_r    <= depth_s;
            empty_r    <= (depth_s == DEPTH_ZERO);
            full_r     <= (depth_s == DEPTH_MAX);
            ack_r      <= (state_s == ST_DONE);
            dsp_psh_r  <= psh_done_s;
            dsp_pul_r  <= pul_done_s;
            dsp_rst_r  <= (state_s == ST_CLR);
            cyc_r      <= cyc_s;
            we_r       <= (state_s == ST_PSH);
            adr_r      <= cyc_s ? adr_s : ADR_ZERO;
            dat_r      <= (state_s == ST_PSH) ? dat_s : CELL_ZERO;
            if (pul_done_s) begin
                pul_data_r <= ram2ips_dat_i;
            end else begin
                pul_data_r <= pul_data_r;
            end
`ifdef IPS_SAFE_EN
            of_r       <= of_s;
            uf_r       <= uf_s;
`endif
        end
    end

    assign ips2us_ack_o      = ack_r;
    assign ips2us_pul_data_o = pul_data_r;
    assign ips2us_empty_o    = empty_r;
    assign ips2us_full_o     = full_r;
    assign ips2dsp_psh_o     = dsp_psh_r;
    assign ips2dsp_pul_o     = dsp_pul_r;
    assign ips2dsp_rst_o     = dsp_rst_r;
    assign ips2ram_cyc_o     = cyc_r;
    assign ips2ram_stb_o     = cyc_r;
    assign ips2ram_we_o      = we_r;
    assign ips2ram_adr_o     = adr_r;
    assign ips2ram_dat_o     = dat_r;
`ifdef IPS_SAFE_EN
    assign ips2excpt_of_o    = of_r;
    assign ips2excpt_uf_o    = uf_r;
`else
    assign ips2excpt_of_o    = 1'b0;
    assign ips2excpt_uf_o    = 1'b0;
`endif

endmodule

// File: tb/tb_n1_ips_ctrl.sv
// tb_n1_ips_ctrl: n1_ips_ctrl with SP_WIDTH=2, bench AGU and wait-state RAM, checked against a stack model.
// Honours IPS_SAFE_EN the same way as the design.

module tb_n1_ips_ctrl;

    localparam int SPW = 2;
    localparam int CW  = 16;
    localparam int CAP = 4;

    logic           clk = 1'b0;
    logic           sync_rst;
    logic           psh, pul, rst;
    logic [CW-1:0]  psh_data;
    logic           ack, empty, full, dpsh, dpul, drst;
    logic [CW-1:0]  pul_data;
    logic [SPW-1:0] lsp;
    logic           cyc, stb, we, ram_ack, of, uf;
    logic [SPW-1:0] adr;
    logic [CW-1:0]  dat_o, ram_dat;

    always #5 clk = ~clk;

    n1_ips_ctrl #(.SP_WIDTH(SPW), .CELL_WIDTH(CW)) dut (
        .clk_i(clk), .sync_rst_i(sync_rst),
        .us2ips_psh_i(psh), .us2ips_pul_i(pul), .us2ips_rst_i(rst),
        .us2ips_psh_data_i(psh_data),
        .ips2us_ack_o(ack), .ips2us_pul_data_o(pul_data),
        .ips2us_empty_o(empty), .ips2us_full_o(full),
        .ips2dsp_psh_o(dpsh), .ips2dsp_pul_o(dpul), .ips2dsp_rst_o(drst),
        .dsp2ips_lsp_i(lsp),
        .ips2ram_cyc_o(cyc), .ips2ram_stb_o(stb), .ips2ram_we_o(we),
        .ips2ram_adr_o(adr), .ips2ram_dat_o(dat_o),
        .ram2ips_ack_i(ram_ack), .ram2ips_dat_i(ram_dat),
        .ips2excpt_of_o(of), .ips2excpt_uf_o(uf)
    );

    // AGU: next free address, stack grows downwards
    always @(posedge clk) begin
        if (sync_rst || drst) lsp <= 2'd3;
        else if (dpsh)        lsp <= lsp - 2'd1;
        else if (dpul)        lsp <= lsp + 2'd1;
    end

    // RAM with a programmable number of wait states before ack
    int            ram_wait = 0;
    int            wcnt = 0;
    logic          mem_clr;
    logic [CW-1:0] mem [CAP];
    assign ram_ack = stb && (wcnt == ram_wait);
    assign ram_dat = mem[adr];
    always @(posedge clk) begin
        if (stb && !ram_ack) wcnt <= wcnt + 1;
        else                 wcnt <= 0;
        if (mem_clr) begin
            for (int i = 0; i < CAP; i++) mem[i] <= '0;
        end else if (ram_ack && we) begin
            mem[adr] <= dat_o;
        end
    end

    // Reference model: depth counter plus the cell contents the stack should hold
    int            m_depth;
    logic [CW-1:0] m_mem [CAP];
    logic [CW-1:0] m_pul;

    int total = 0;
    int bad   = 0;

    int             r_lat;
    logic [SPW-1:0] r_adr;
    logic           r_of, r_uf;

    function automatic int m_lsp();
        return (CAP - 1 - m_depth) & (CAP - 1);
    endfunction

    function automatic bit is_blocked(input int kind);
`ifdef IPS_SAFE_EN
        return (kind == 0 && m_depth == CAP) || (kind == 1 && m_depth == 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_reset();
        chk("rst_ack", ack, 0);       chk("rst_pul_data", pul_data, 0);
        chk("rst_empty", empty, 1);   chk("rst_full", full, 0);
        chk("rst_dpsh", dpsh, 0);     chk("rst_dpul", dpul, 0);
        chk("rst_drst", drst, 0);     chk("rst_cyc", cyc, 0);
        chk("rst_stb", stb, 0);       chk("rst_we", we, 0);
        chk("rst_adr", adr, 0);       chk("rst_dat", dat_o, 0);
        chk("rst_of", of, 0);         chk("rst_uf", uf, 0);
    endtask

    task automatic drop();
        psh = 1'b0; pul = 1'b0; rst = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        sync_rst = 1'b1;
        drop();
        @(negedge clk);
        @(negedge clk);
        check_reset();
        sync_rst = 1'b0;
        m_depth = 0;
        m_pul   = '0;
        @(negedge clk);
        check_reset();
    endtask

    task automatic issue(input bit p, input bit l, input bit r, input logic [CW-1:0] d);
        @(negedge clk);
        psh = p; pul = l; rst = r; psh_data = d;
    endtask

    // Requests are already driven; watch every cycle until ack, then settle the model.
    // kind: 0 push, 1 pull, 2 clear. abort_at > 0 raises rst after that many cycles.
    task automatic run_op(input int kind, input int abort_at);
        int             exp_lat, exp_bus, exp_psh, exp_pul, exp_rst;
        int             nbus, npsh, npul, nrst;
        bit             blk, seen, exp_of, exp_uf;
        logic [SPW-1:0] exp_adr;
        blk     = is_blocked(kind);
        exp_adr = (kind == 0) ? SPW'(m_lsp()) : SPW'((m_lsp() + 1) & (CAP - 1));
        exp_psh = 0; exp_pul = 0; exp_rst = 0;
        exp_of  = 1'b0; exp_uf = 1'b0;
        if (abort_at > 0) begin
            exp_lat = abort_at + 2; exp_bus = abort_at; exp_rst = 1;
        end else if (kind == 2) begin
            exp_lat = 2; exp_bus = 0; exp_rst = 1;
        end else if (blk) begin
            exp_lat = 1; exp_bus = 0;
            exp_of = (kind == 0); exp_uf = (kind == 1);
        end else begin
            exp_lat = 2 + ram_wait; exp_bus = ram_wait + 1;
            exp_psh = (kind == 0) ? 1 : 0; exp_pul = (kind == 1) ? 1 : 0;
        end
        nbus = 0; npsh = 0; npul = 0; nrst = 0; seen = 1'b0;
        r_lat = 0; r_adr = '0; r_of = 1'b0; r_uf = 1'b0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            chk("stb_eq_cyc", stb, cyc);
            if (cyc) begin
                nbus++;
                r_adr = adr;
                chk("bus_we", we, (kind == 0) ? 1 : 0);
                chk("bus_adr", adr, exp_adr);
                if (kind == 0) chk("bus_dat", dat_o, psh_data);
            end
            npsh += dpsh; npul += dpul; nrst += drst;
            if (ack) begin
                seen = 1'b1; r_lat = n; r_of = of; r_uf = uf;
            end else begin
                chk("of_idle", of, 0);
                chk("uf_idle", uf, 0);
                chk("empty_hold", empty, (m_depth == 0) ? 1 : 0);
                chk("full_hold", full, (m_depth == CAP) ? 1 : 0);
            end
            if (n == abort_at) rst = 1'b1;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL ack_timeout: no ack after 40 cycles, expected one after %0d", exp_lat);
        end
        chk("latency", r_lat, exp_lat);
        chk("bus_cycles", nbus, exp_bus);
        chk("agu_psh", npsh, exp_psh);
        chk("agu_pul", npul, exp_pul);
        chk("agu_rst", nrst, exp_rst);
        chk("of_flag", r_of, exp_of);
        chk("uf_flag", r_uf, exp_uf);
        if (abort_at > 0 || kind == 2) begin
            m_depth = 0;
        end else if (!blk) begin
            if (kind == 0) begin
                m_mem[exp_adr] = psh_data;
                m_depth = (m_depth + 1) & (2 * CAP - 1);
            end else begin
                m_pul = m_mem[exp_adr];
                m_depth = (m_depth - 1) & (2 * CAP - 1);
            end
        end
        chk("pul_data", pul_data, m_pul);
        chk("empty", empty, (m_depth == 0) ? 1 : 0);
        chk("full", full, (m_depth == CAP) ? 1 : 0);
    endtask

    task automatic op(input int kind, input logic [CW-1:0] d, input int waits);
        ram_wait = waits;
        issue(kind == 0, kind == 1, kind == 2, d);
        run_op(kind, 0);
        drop();
    endtask

    initial begin
        sync_rst = 1'b1;
        mem_clr  = 1'b1;
        psh_data = '0;
        drop();
        for (int i = 0; i < CAP; i++) m_mem[i] = '0;
        reset_dut();
        mem_clr = 1'b0;

        // 1: first push lands at the top address, ack in the third cycle counting the request cycle
        op(0, 16'hA5A5, 0);
        chk("t1_lat", r_lat, 2);
        chk("t1_adr", r_adr, 3);
        chk("t1_empty", empty, 0);

        // 2: LIFO order and addresses
        reset_dut();
        op(0, 16'h1111, 0);
        op(0, 16'h2222, 1);
        op(1, 16'h0000, 0);
        chk("t2_adr_a", r_adr, 2);
        chk("t2_data_a", pul_data, 16'h2222);
        op(1, 16'h0000, 2);
        chk("t2_adr_b", r_adr, 3);
        chk("t2_data_b", pul_data, 16'h1111);
        chk("t2_empty", empty, 1);

        // 3: fill, then one push too many
        reset_dut();
        for (int i = 0; i < CAP; i++) op(0, 16'(16'h0101 * (i + 1)), 0);
        chk("t3_full", full, 1);
        op(0, 16'h5555, 0);
`ifdef IPS_SAFE_EN
        chk("t3_of", r_of, 1);
        chk("t3_lat", r_lat, 1);
`else
        chk("t3_adr", r_adr, 3);
`endif

        // 4: pull from an empty stack
        reset_dut();
        op(1, 16'h0000, 0);
`ifdef IPS_SAFE_EN
        chk("t4_uf", r_uf, 1);
        chk("t4_pul_data", pul_data, 0);
`else
        chk("t4_adr", r_adr, 0);
`endif

        // 5: all three requests at once; clear wins, push follows, pull dropped afterwards
        reset_dut();
        ram_wait = 0;
        issue(1'b1, 1'b1, 1'b1, 16'h7E7E);
        run_op(2, 0);
        rst = 1'b0;
        @(negedge clk);
        run_op(0, 0);
        drop();
        chk("t5_lat_push", r_lat, 2);
        chk("t5_empty", empty, 0);

        // 6: abort a slow pull exactly when the late RAM ack arrives
        reset_dut();
        op(0, 16'h3C3C, 0);
        ram_wait = 3;
        issue(1'b0, 1'b1, 1'b0, 16'h0000);
        run_op(1, 4);
        drop();
        chk("t6_empty", empty, 1);
        chk("t6_pul_data", pul_data, 0);

        // 7: synchronous reset in the middle of a bus cycle
        reset_dut();
        ram_wait = 3;
        issue(1'b1, 1'b0, 1'b0, 16'hBEEF);
        @(negedge clk);
        @(negedge clk);
        chk("t7_busy", cyc, 1);
        reset_dut();

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            int r, k;
            r = $urandom_range(0, 9);
            k = (r < 5) ? 0 : ((r < 9) ? 1 : 2);
            op(k, 16'($urandom), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
